rpn_engine: RTL

//   Reverse-Polish evaluator that acts as the initiator on the stack push/pop interface.

---
 rtl/rpn_pkg.sv | 26 ++
 rtl/rpn_engine_if.sv | 26 ++
 rtl/rpn_alu.sv | 29 ++
 rtl/rpn_engine.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Shared constants and state encoding for the RPN evaluator.
package rpn_pkg;

    // Operator opcodes carried in tok_data[1:0] when tok_kind is an operator
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    // Token kinds
    localparam logic KIND_OPERAND  = 1'b0;
    localparam logic KIND_OPERATOR = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        PUSH,
        POP_B,
        WAIT_B,
        POP_A,
        WAIT_A,
        EXEC,
        PUSH_R,
        EMIT
    } state_t;

endpackage

// File: rtl/rpn_engine_if.sv
// Token input and stack request/response signals of the RPN evaluator.
// master: the engine (token consumer, stack initiator).
// slave:  the environment (token source and external stack).
interface rpn_engine_if #(
    parameter int WIDTH = 16
);
    logic             tok_iv;
    logic             tok_kind;
    logic [WIDTH-1:0] tok_data;
    logic             tok_rdy;
    logic             stk_iv;
    logic             stk_op;
    logic [WIDTH-1:0] stk_in;
    logic [WIDTH-1:0] stk_out;
    logic             stk_ov;

    modport master (
        input  tok_iv, tok_kind, tok_data, stk_out, stk_ov,
        output tok_rdy, stk_iv, stk_op, stk_in
    );

    modport slave (
        output tok_iv, tok_kind, tok_data, stk_out, stk_ov,
        input  tok_rdy, stk_iv, stk_op, stk_in
    );
endinterface

// File: rtl/rpn_alu.sv
// Combinational operator unit: r = a op b, WIDTH-bit modular arithmetic.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] r_o
);
    logic [2*WIDTH-1:0] prod;

    // Full product; only the low WIDTH bits are kept
    always_comb begin
        prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    end

    // Operator select; SUB takes a as the deeper operand
    always_comb begin
        r_o = '0;
        case (op_i)
            OP_ADD:  r_o = a_i + b_i;
            OP_SUB:  r_o = a_i - b_i;
            OP_MUL:  r_o = prod[WIDTH-1:0];
            default: r_o = b_i;
        endcase
    end
endmodule

// File: rtl/rpn_engine.sv
// RPN evaluator: accepts operand/operator tokens, drives an external stack,
// evaluates binary operators and emits PEEK results. Tracks stack occupancy
// and flags overflow, underflow and pop-response timeout in a sticky err.
module rpn_engine
    import rpn_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 10,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    rpn_engine_if.master     bus,
    output logic             res_v,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       depth,
    output logic             err
);
    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  DEPTH_W  = 4'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [3:0]       depth_q, depth_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       op_q, op_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic [WIDTH-1:0] alu_r;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .r_o  (alu_r)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            depth_q <= '0;
            err_q   <= 1'b0;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            op_q    <= OP_ADD;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            op_q    <= op_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and datapath updates; occupancy drops when a pop is issued
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        err_d   = err_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        op_d    = op_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (bus.tok_iv) begin
                    if (bus.tok_kind == KIND_OPERAND) begin
                        if (depth_q == DEPTH_W) begin
                            err_d = 1'b1;
                        end else begin
                            data_d  = bus.tok_data;
                            state_d = PUSH;
                        end
                    end else begin
                        op_d = bus.tok_data[1:0];
                        if ((bus.tok_data[1:0] == OP_PEEK) ? (depth_q == 4'd0)
                                                           : (depth_q < 4'd2)) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = POP_B;
                        end
                    end
                end
            end
            PUSH: begin
                depth_d = depth_q + 4'd1;
                state_d = IDLE;
            end
            POP_B: begin
                depth_d = depth_q - 4'd1;
                tmo_d   = '0;
                state_d = WAIT_B;
            end
            WAIT_B: begin
                if (bus.stk_ov) begin
                    b_d = bus.stk_out;
                    if (op_q == OP_PEEK) begin
                        res_d   = bus.stk_out;
                        state_d = EMIT;
                    end else begin
                        state_d = POP_A;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            POP_A: begin
                depth_d = depth_q - 4'd1;
                tmo_d   = '0;
                state_d = WAIT_A;
            end
            WAIT_A: begin
                if (bus.stk_ov) begin
                    a_d     = bus.stk_out;
                    state_d = EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            EXEC: begin
                data_d  = alu_r;
                state_d = PUSH_R;
            end
            PUSH_R: begin
                depth_d = depth_q + 4'd1;
                state_d = IDLE;
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; tok_rdy is forced low while reset is held
    always_comb begin
        bus.tok_rdy = reset && (state_q == IDLE);
        bus.stk_iv  = (state_q == PUSH) || (state_q == POP_B) ||
                      (state_q == POP_A) || (state_q == PUSH_R);
        bus.stk_op  = (state_q == POP_B) || (state_q == POP_A);
        bus.stk_in  = data_q;
        res_v       = (state_q == EMIT);
        res         = res_q;
        depth       = depth_q;
        err         = err_q;
    end
endmodule
